dff_bank_arbiter: RTL
=====================

DFF_BANK_ARBITER -- requirements
Module: dff_bank_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing the register (2..8).
REQ-002 Parameter WIDTH, default 8, SHALL set the data width of the shared D register.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req  input  NREQ  SHALL be the per-requester write request, level, held until ack.
REQ-006 d  input  NREQ*WIDTH  SHALL carry the write data, requester i in bits [i*WIDTH +: WIDTH].
REQ-007 lock  input  1  SHALL be present only when DFF_ARB_LOCK_EN is defined; it requests grant retention.
REQ-008 gnt  output  NREQ  SHALL be the registered one-hot grant.
REQ-009 ack  output  NREQ  SHALL pulse one-hot for one cycle per completed write.
REQ-010 q  output  WIDTH  SHALL be the shared D-register contents.
REQ-011 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE and GRANT, plus LOCK only when DFF_ARB_LOCK_EN is defined.
REQ-013 IDLE: if any req bit is set at the clock edge, the FSM SHALL select the first set bit searching upward from ptr with wrap NREQ-1 -> 0, register gnt one-hot to it, and enter GRANT.
REQ-014 IDLE with req == 0 SHALL keep gnt == 0 and hold the state.
REQ-015 GRANT with req[sel] high at the edge SHALL load q <= d[sel], assert ack[sel] for the following cycle, set ptr <= (sel+1) mod NREQ, clear gnt, and return to IDLE.
REQ-016 GRANT with req[sel] low (request withdrawn) SHALL leave q unchanged, assert no ack, leave ptr unchanged, clear gnt, and return to IDLE.
REQ-017 Request-to-ack latency SHALL be 2 cycles; the sustained throughput SHALL be one write per 2 cycles.
REQ-018 Requests arriving for non-selected requesters during GRANT SHALL wait; no request is dropped while req stays high.
REQ-019 Simultaneous requests SHALL be resolved only by the round-robin pointer, with no fixed priority.
REQ-020 gnt and ack SHALL be one-hot or zero in every cycle.

Reset
REQ-021 Assertion of rst_n low SHALL immediately set q = 0, gnt = 0, ack = 0, busy = 0, ptr = 0, and state = IDLE.
REQ-022 A reset during GRANT or LOCK SHALL abort the operation with no write and no ack.
REQ-023 The first edge after reset release SHALL be treated as an ordinary IDLE cycle.

Configuration
REQ-024 Macro DFF_ARB_LOCK_EN SHALL compile in the lock port and the LOCK state.
REQ-025 With the macro defined, GRANT with req[sel] and lock both high SHALL perform the REQ-015 write but enter LOCK with gnt held.
REQ-026 In LOCK, each cycle with req[sel] high SHALL write q <= d[sel] and assert ack[sel] the next cycle.
REQ-027 LOCK SHALL exit to IDLE when lock or req[sel] is low; ptr SHALL then advance to (sel+1) mod NREQ.
REQ-028 With the macro undefined, there SHALL be no lock port or LOCK state, and the behaviour SHALL be exactly REQ-012..REQ-020.

Structure
REQ-029 A shared package dff_arb_pkg SHALL hold the default NREQ/WIDTH constants and the FSM state typedef (IDLE, GRANT, LOCK).
REQ-030 The round-robin selector SHALL be one sub-module, rr_select: inputs req and ptr; outputs the one-hot pick and a valid flag.

Verification
REQ-031 Reset: hold rst_n low for 2 cycles with req = 4'b1111 -> q = 0, gnt = 0, ack = 0, busy = 0 throughout.
REQ-032 Single requester: req = 4'b0100, d[2] = 8'hA5 -> gnt = 4'b0100 at cycle 1, q = 8'hA5 and ack = 4'b0100 at cycle 2.
REQ-033 All requesting from ptr = 0, each dropping req after its ack -> grant order 0,1,2,3 with exactly one ack every 2 cycles.
REQ-034 Wrap: ptr = 3 with req = 4'b1001 -> requester 3 is granted first, then requester 0.
REQ-035 Withdrawal: req[1] dropped during GRANT -> q is unchanged, there is no ack, and ptr stays 1.
REQ-036 With DFF_ARB_LOCK_EN: lock = 1 and req[0] held for 4 cycles with d[0] = 1,2,3,4 -> four acks, q ends at 4, and no other gnt occurs.

Source files
------------

// File: rtl/dff_arb_pkg.sv
// Shared constants and FSM state type for the round-robin D-register arbiter.
// The LOCK state exists only when DFF_ARB_LOCK_EN is defined.
package dff_arb_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1
`ifdef DFF_ARB_LOCK_EN
    , LOCK = 2'd2
`endif
  } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// Round-robin picker: first set req bit at or above ptr, wrapping NREQ-1 -> 0.
// Purely combinational, no latency; no backpressure (pure function of its inputs).
module rr_select #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic            vld
);

  always_comb begin
    pick = '0;
    vld  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!vld && req[(int'(ptr) + i) % NREQ]) begin
        pick[(int'(ptr) + i) % NREQ] = 1'b1;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter for one shared D register; DFF_ARB_LOCK_EN adds lock/LOCK.
// Latency req->ack 2 cycles, one write per 2 cycles; requesters hold req until ack.
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] d,
`ifdef DFF_ARB_LOCK_EN
  input  logic                  lock,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic                  busy
);

  localparam int PW = $clog2(NREQ);

  arb_state_t       state, state_nxt;
  logic [NREQ-1:0]  gnt_nxt, ack_nxt, pick;
  logic             pick_vld, req_sel;
  logic [WIDTH-1:0] q_nxt, d_sel;
  logic [PW-1:0]    ptr, ptr_nxt, sel, sel_adv;

  rr_select #(.NREQ(NREQ), .PW(PW)) u_rr_select (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .vld  (pick_vld)
  );

  // The registered one-hot grant is the only record of the selected requester.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) sel = PW'(i);
    end
  end

  assign d_sel   = d[int'(sel)*WIDTH +: WIDTH];
  assign req_sel = |(req & gnt);
  assign sel_adv = (sel == PW'(NREQ - 1)) ? '0 : sel + 1'b1;
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ack_nxt   = '0;
    q_nxt     = q;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        gnt_nxt = pick_vld ? pick : '0;
        if (pick_vld) state_nxt = GRANT;
      end
      GRANT: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
        if (req_sel) begin
          q_nxt   = d_sel;
          ack_nxt = gnt;
          ptr_nxt = sel_adv;
`ifdef DFF_ARB_LOCK_EN
          // Retained grant: pointer advances only when the lock is released.
          if (lock) begin
            gnt_nxt   = gnt;
            state_nxt = LOCK;
            ptr_nxt   = ptr;
          end
`endif
        end
      end
`ifdef DFF_ARB_LOCK_EN
      LOCK: begin
        if (req_sel) begin
          q_nxt   = d_sel;
          ack_nxt = gnt;
        end
        if (!(req_sel && lock)) begin
          gnt_nxt   = '0;
          state_nxt = IDLE;
          ptr_nxt   = sel_adv;
        end
      end
`endif
      default: begin
        gnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      ack   <= '0;
      q     <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      ack   <= ack_nxt;
      q     <= q_nxt;
      ptr   <= ptr_nxt;
    end
  end

endmodule
